// File: rtl/chunk_adder_if.sv
// Purpose: operand/result bundle for chunk_adder (start/busy/done handshake plus data).
// Latency: none, wires only.
// Backpressure: none; the requester must hold off while busy is high because start is ignored then.
// Ports: master drives start/sub/a/b/c_in and observes busy/done/s/c_out/ovf; slave is the reverse.
interface chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, s, c_out, ovf
    );
endinterface

// File: rtl/chunk_adder.sv
// Purpose: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one ripple slice.
// Latency: WIDTH/CHUNK cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is only taken in IDLE or DONE; while busy it is ignored.
// Ports: clk, rst_n (async, active low); bus (slave) carries start/sub/a/b/c_in in and
//        busy/done/s/c_out/ovf out. s/c_out/ovf hold until the next completion.
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    chunk_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cy;
    logic             msb_cin;
    logic             accept;

    assign base    = 32'(k_q) * 32'(CHUNK);
    assign slice_a = opa_q[base +: CHUNK];
    assign slice_b = opb_q[base +: CHUNK];

    assign {slice_cy, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};

    // Carry into the slice's top bit recovered from sum = a ^ b ^ cin; on the last
    // chunk this is the carry into the word MSB (equals carry_q when CHUNK = 1).
    assign msb_cin = slice_sum[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];

    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_RUN;
                    // Subtract as a + ~b + ~borrow, so the carry out reads as "no borrow".
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ^ bus.c_in;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                work_d[base +: CHUNK] = slice_sum;
                carry_d               = slice_cy;
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    s_d     = work_d;
                    c_out_d = slice_cy;
                    ovf_d   = msb_cin ^ slice_cy;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // DONE lasts exactly one cycle, so done is a clean pulse straight off the state.
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunk_adder.sv
// Purpose: checks chunk_adder at CHUNK = 4, 16 and 1 side by side against an arithmetic model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_chunk_adder;
    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         c_in  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;

    always #5 clk = ~clk;

    chunk_adder_if #(.WIDTH(W)) if4 ();
    chunk_adder_if #(.WIDTH(W)) if16 ();
    chunk_adder_if #(.WIDTH(W)) if1 ();

    assign if4.start  = start;
    assign if4.sub    = sub;
    assign if4.a      = a;
    assign if4.b      = b;
    assign if4.c_in   = c_in;
    assign if16.start = start;
    assign if16.sub   = sub;
    assign if16.a     = a;
    assign if16.b     = b;
    assign if16.c_in  = c_in;
    assign if1.start  = start;
    assign if1.sub    = sub;
    assign if1.a      = a;
    assign if1.b      = b;
    assign if1.c_in   = c_in;

    chunk_adder #(.WIDTH(W), .CHUNK(4))  u_c4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    chunk_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    chunk_adder #(.WIDTH(W), .CHUNK(1))  u_c1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // index 0: CHUNK=4, 1: CHUNK=16, 2: CHUNK=1
    int nch [3] = '{4, 1, 16};

    logic [2:0]   busy_v, done_v, cout_v, ovf_v;
    logic [W-1:0] s_v [3];

    assign busy_v = {if1.busy,  if16.busy,  if4.busy};
    assign done_v = {if1.done,  if16.done,  if4.done};
    assign cout_v = {if1.c_out, if16.c_out, if4.c_out};
    assign ovf_v  = {if1.ovf,   if16.ovf,   if4.ovf};
    assign s_v[0] = if4.s;
    assign s_v[1] = if16.s;
    assign s_v[2] = if1.s;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic sb, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, output logic [W-1:0] rs, output logic rc,
                                  output logic ro);
        longint ux, uy, sx, sy, lc, r, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lc = ci ? 64'sd1 : 64'sd0;
        if (!sb) begin
            r  = ux + uy + lc;
            sr = sx + sy + lc;
            rc = (r >= (64'sd1 <<< W));
        end else begin
            r  = ux - uy - lc;
            sr = sx - sy - lc;
            rc = (ux >= uy + lc);
        end
        rs = r[W-1:0];
        ro = (sr > 64'sd32767) || (sr < -64'sd32768);
    endfunction

    task automatic run_op(input logic sb, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input bit disturb);
        logic [W-1:0] es;
        logic         ec, eo;
        int           dcyc [3];
        int           bcnt [3];
        int           dn   [3];
        logic [W-1:0] rs   [3];
        logic         rc   [3];
        logic         ro   [3];
        bit           overlap;
        model(sb, x, y, ci, es, ec, eo);
        @(negedge clk);
        sub = sb; a = x; b = y; c_in = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dcyc[i] = -1;
            bcnt[i] = busy_v[i] ? 1 : 0;
            dn[i]   = 0;
            rs[i]   = '0;
            rc[i]   = 1'b0;
            ro[i]   = 1'b0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i] && done_v[i]) overlap = 1'b1;
                if (busy_v[i]) bcnt[i]++;
                if (done_v[i]) begin
                    dn[i]++;
                    if (dcyc[i] < 0) begin
                        dcyc[i] = cyc;
                        rs[i]   = s_v[i];
                        rc[i]   = cout_v[i];
                        ro[i]   = ovf_v[i];
                    end
                end
            end
            // A competing request while the longer variants are still busy.
            if (disturb && cyc == 1) begin
                start = 1'b1; a = ~x; b = x ^ 16'h5A5A; sub = ~sb; c_in = ~ci;
            end
            if (disturb && cyc == 2) start = 1'b0;
        end
        chk("busy_done_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s_n%0d", nch[i]),     32'(rs[i]), 32'(es));
            chk($sformatf("cout_n%0d", nch[i]),  32'(rc[i]), 32'(ec));
            chk($sformatf("ovf_n%0d", nch[i]),   32'(ro[i]), 32'(eo));
            chk($sformatf("lat_n%0d", nch[i]),   32'(dcyc[i]), 32'(nch[i]));
            // CHUNK=16 has already finished and legitimately accepts the competing request.
            if (!(disturb && nch[i] < 3)) begin
                chk($sformatf("busy_n%0d", nch[i]),  32'(bcnt[i]), 32'(nch[i]));
                chk($sformatf("ndone_n%0d", nch[i]), 32'(dn[i]), 32'd1);
                chk($sformatf("hold_n%0d", nch[i]),  32'(s_v[i]), 32'(es));
            end
        end
    endtask

    task automatic directed(input logic sb, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
        run_op(sb, x, y, ci, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dir_s_n%0d", nch[i]),    32'(s_v[i]),    32'(es));
            chk($sformatf("dir_cout_n%0d", nch[i]), 32'(cout_v[i]), 32'(ec));
            chk($sformatf("dir_ovf_n%0d", nch[i]),  32'(ovf_v[i]),  32'(eo));
        end
    endtask

    initial begin
        int           first  [3];
        int           second [3];
        logic [W-1:0] s2     [3];
        bit           overlap;
        int           ndone;

        #3;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_n%0d", nch[i]),
                {busy_v[i], done_v[i], cout_v[i], ovf_v[i], 12'd0, s_v[i]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        directed(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        directed(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Start pulsed mid-run with different operands must not disturb the result.
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1);

        // Start held high: second operation follows straight out of DONE.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0001; b = 16'h0001;
        overlap = 1'b0;
        for (int i = 0; i < 3; i++) begin
            first[i]  = -1;
            second[i] = -1;
            s2[i]     = '0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i] && done_v[i]) overlap = 1'b1;
                if (done_v[i]) begin
                    if (first[i] < 0) first[i] = cyc;
                    else if (second[i] < 0) begin
                        second[i] = cyc;
                        s2[i]     = s_v[i];
                    end
                end
            end
            if (cyc == 17) start = 1'b0;
        end
        chk("b2b_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_first_n%0d", nch[i]),  32'(first[i]),  32'(nch[i]));
            chk($sformatf("b2b_second_n%0d", nch[i]), 32'(second[i]), 32'(2 * nch[i] + 1));
            chk($sformatf("b2b_s2_n%0d", nch[i]),     32'(s2[i]),     32'h0002);
        end

        // Leave nonzero results, then reset during the second RUN cycle.
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("midrst_n%0d", nch[i]),
                {busy_v[i], done_v[i], cout_v[i], ovf_v[i], 12'd0, s_v[i]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done_v != 3'b000) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("midrst_after_n%0d", nch[i]),
                {busy_v[i], done_v[i], cout_v[i], ovf_v[i], 12'd0, s_v[i]}, 32'd0);

        for (int n = 0; n < 1000; n++) begin
            logic         rsb, rci;
            logic [W-1:0] rx, ry;
            rsb = 1'($urandom_range(0, 1));
            rci = 1'($urandom_range(0, 1));
            rx  = W'($urandom);
            ry  = W'($urandom);
            run_op(rsb, rx, ry, rci, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
